multicycle_alu: RTL and testbench
=================================

# multicycle_alu

Parametrised, clocked ALU that succeeds the combinational 32-bit ripple ALU. It keeps the AND/OR/ADD/SUB/SLT opcode encoding and flags. It adds iterative multiply and logical shifts, and a valid/ready handshake on both the operand and result sides. It sits between the register-read stage and writeback and stalls upstream while a multi-cycle operation is in flight.

## Interface
- WIDTH, 32: operand/result width; ≥ 2, power of two.
- SHW, $clog2(WIDTH): shift-amount width, derived; not overridden.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; sampled on rising edge of clk.
- in_valid  in  1  operands/op presented.
- in_ready  out  1  block can accept; high only in IDLE and not in reset.
- op  in  4  opcode: 0 AND, 1 OR, 2 ADD, 6 SUB, 7 SLT, 8 MUL, 9 SLL, 10 SRL; others illegal.
- a  in  WIDTH  operand a.
- b  in  WIDTH  operand b; shifts use b[SHW-1:0] as shift amount.
- out_valid  out  1  result and flags valid.
- out_ready  in  1  consumer takes result.
- result  out  WIDTH  operation result.
- zero  out  1  result == 0.
- overflow  out  1  signed overflow (ADD/SUB/SLT); for MUL, nonzero upper half of the product.
- cout  out  1  carry out of MSB (ADD/SUB/SLT); 0 otherwise.

## Operation
- The input is captured in the cycle where in_valid && in_ready: a, b, and op are registered, and in_ready drops.
- States: IDLE → (accept) → BUSY or DONE; BUSY → DONE when the iteration count is exhausted; DONE → (out_valid && out_ready) → IDLE.
- Single-cycle ops (AND, OR, ADD, SUB, SLT, illegal): go IDLE → DONE directly.
- SUB = a + ~b + 1. overflow = carry into MSB XOR carry out of MSB. cout = carry out of MSB.
- SLT: result = {0…, sumMSB XOR overflow}. overflow and cout are taken from the subtraction. zero reflects the result.
- MUL: unsigned shift-add, one partial product per cycle, WIDTH iterations.
  - result = product[WIDTH-1:0].
  - overflow = |product[2·WIDTH-1:WIDTH].
  - cout = 0.
- SLL/SRL: shift by one bit per cycle, shamt iterations, zero fill. shamt = 0 skips BUSY. overflow = cout = 0.
- Illegal op: result = 0, zero = 1, overflow = cout = 0.
- In DONE, result and flags are held stable until accepted. Inputs are ignored outside IDLE.
- Reset (any state, including mid-MUL or mid-shift) aborts the operation, with no out_valid. All outputs are forced to their reset values: out_valid = 0, result = 0, zero = 0, overflow = 0, cout = 0, in_ready = 0 while reset is high, state = IDLE.

## Timing
- Acceptance at edge T.
  - Single-cycle ops: out_valid is high from T+1.
  - MUL: out_valid is high from T+WIDTH+1.
  - SLL/SRL: out_valid is high from T+shamt+1 (T+1 when shamt = 0).
- The result transfers at the edge where out_valid && out_ready. in_ready rises the following cycle, so there is no same-cycle turnaround. Maximum throughput is one op per 2 cycles.
- out_valid, result and flags are registered outputs. in_ready is decoded from state only, with no combinational path from in_valid or out_ready.
- The iteration counter is SHW+1 bits wide and is loaded at acceptance. BUSY exits on the edge where the counter reaches 1.
- in_ready is high in the first cycle after reset deasserts.

## Structure
- Package alu_pkg holds:
  - opcode localparams (OP_AND=0, OP_OR=1, OP_ADD=2, OP_SUB=6, OP_SLT=7, OP_MUL=8, OP_SLL=9, OP_SRL=10);
  - the state encoding (IDLE, BUSY, DONE);
  - the flag bit positions.
- One sub-module, alu_addsub: combinational WIDTH-bit adder with sub control, producing sum, cout and overflow. It is shared by ADD/SUB/SLT and by the MUL accumulate step.
- Datapath registers: operand A, operand B, product (2·WIDTH), counter, and an op register. The FSM and shifters are inline.

## Test plan
- ADD a=0x7FFFFFFF, b=1 → result 0x80000000, overflow=1, cout=0, zero=0, out_valid at T+1. SUB 45−15 → 30, cout=1.
- SLT a=75, b=120 → result 1. SLT a=0xFFFFFFFF, b=1 → 1. SLT a=5, b=5 → result 0, zero=1.
- MUL 13×16 → 208, overflow=0, out_valid at T+33. MUL 0x10000×0x10000 → result 0, zero=1, overflow=1.
- SLL a=1, b=31 → 0x80000000 at T+32. SRL a=0x80000000, b=0 → unchanged at T+1. Illegal op 15 → result 0, zero=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid. Required response: result and flags stable, in_ready=0, and a concurrent in_valid with new operands is ignored. On out_ready=1, the transfer occurs and in_ready rises next cycle.
- Assert reset 10 cycles into a MUL. Required response: out_valid never asserts and all outputs return to reset values. After deassertion, ADD 2+3 → 5 at T+1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcodes, FSM encoding and flag layout for the multicycle ALU.
package alu_pkg;

    localparam logic [3:0] OP_AND = 4'd0;
    localparam logic [3:0] OP_OR  = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd6;
    localparam logic [3:0] OP_SLT = 4'd7;
    localparam logic [3:0] OP_MUL = 4'd8;
    localparam logic [3:0] OP_SLL = 4'd9;
    localparam logic [3:0] OP_SRL = 4'd10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } alu_state_t;

    localparam int FLAG_ZERO     = 0;
    localparam int FLAG_OVERFLOW = 1;
    localparam int FLAG_COUT     = 2;
    localparam int FLAG_BITS     = 3;

    function automatic logic is_shift(input logic [3:0] code);
        return (code == OP_SLL) || (code == OP_SRL);
    endfunction

    function automatic logic [FLAG_BITS-1:0] pack_flags(input logic z, input logic ovf, input logic c);
        logic [FLAG_BITS-1:0] f;
        f                = {FLAG_BITS{1'b0}};
        f[FLAG_ZERO]     = z;
        f[FLAG_OVERFLOW] = ovf;
        f[FLAG_COUT]     = c;
        return f;
    endfunction

endpackage

// File: rtl/alu_addsub.sv
// Combinational WIDTH-bit adder/subtractor with carry-out and signed overflow.
module alu_addsub #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   full;
    logic             carry_msb;

    // Subtraction is a + ~b + 1; the carry into the MSB is recovered from its sum bit.
    always_comb begin
        b_eff     = sub ? ~b : b;
        full      = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
        sum       = full[WIDTH-1:0];
        cout      = full[WIDTH];
        carry_msb = a[WIDTH-1] ^ b_eff[WIDTH-1] ^ full[WIDTH-1];
        overflow  = carry_msb ^ cout;
    end

endmodule

// File: rtl/multicycle_alu.sv
// Clocked ALU with valid/ready handshakes: single-cycle logic/arith ops,
// iterative shift-add multiply and one-bit-per-cycle logical shifts.
module multicycle_alu
    import alu_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             cout
);

    localparam logic [SHW:0] CNT_ONE  = (SHW+1)'(1'b1);
    localparam logic [SHW:0] CNT_FULL = (SHW+1)'(WIDTH);

    alu_state_t             state;
    alu_state_t             next_state;
    logic [WIDTH-1:0]       opa;
    // Low half starts as operand B (the multiplier) and is consumed as the product shifts in.
    logic [2*WIDTH-1:0]     product;
    logic [SHW:0]           count;
    logic [3:0]             op_reg;
    logic [FLAG_BITS-1:0]   flags;

    logic [WIDTH-1:0]       add_a;
    logic [WIDTH-1:0]       add_b;
    logic                   add_sub;
    logic [WIDTH-1:0]       add_sum;
    logic                   add_cout;
    logic                   add_ovf;

    logic [WIDTH-1:0]       single_res;
    logic [FLAG_BITS-1:0]   single_flags;
    logic [WIDTH:0]         mul_hi;
    logic [2*WIDTH-1:0]     mul_next;
    logic [WIDTH-1:0]       shift_next;

    assign in_ready = (state == IDLE) && !reset;
    assign zero     = flags[FLAG_ZERO];
    assign overflow = flags[FLAG_OVERFLOW];
    assign cout     = flags[FLAG_COUT];

    alu_addsub #(.WIDTH(WIDTH)) u_addsub (
        .a        (add_a),
        .b        (add_b),
        .sub      (add_sub),
        .sum      (add_sum),
        .cout     (add_cout),
        .overflow (add_ovf)
    );

    // Adder serves the multiply accumulate while busy, the incoming operands otherwise.
    always_comb begin
        if (state == BUSY) begin
            add_a   = product[2*WIDTH-1:WIDTH];
            add_b   = opa;
            add_sub = 1'b0;
        end else begin
            add_a   = a;
            add_b   = b;
            add_sub = (op == OP_SUB) || (op == OP_SLT);
        end
    end

    // Result and flags of ops that finish at acceptance.
    always_comb begin
        single_res   = {WIDTH{1'b0}};
        single_flags = {FLAG_BITS{1'b0}};
        case (op)
            OP_AND: single_res = a & b;
            OP_OR:  single_res = a | b;
            OP_ADD, OP_SUB: begin
                single_res                   = add_sum;
                single_flags[FLAG_OVERFLOW]  = add_ovf;
                single_flags[FLAG_COUT]      = add_cout;
            end
            OP_SLT: begin
                single_res                   = {{(WIDTH-1){1'b0}}, add_sum[WIDTH-1] ^ add_ovf};
                single_flags[FLAG_OVERFLOW]  = add_ovf;
                single_flags[FLAG_COUT]      = add_cout;
            end
            OP_SLL, OP_SRL: single_res = a;
            default: single_res = {WIDTH{1'b0}};
        endcase
        single_flags[FLAG_ZERO] = (single_res == {WIDTH{1'b0}});
    end

    // One multiply step and one shift step per busy cycle.
    always_comb begin
        mul_hi     = product[0] ? {add_cout, add_sum} : {1'b0, product[2*WIDTH-1:WIDTH]};
        mul_next   = {mul_hi, product[WIDTH-1:1]};
        shift_next = (op_reg == OP_SLL) ? {opa[WIDTH-2:0], 1'b0} : {1'b0, opa[WIDTH-1:1]};
    end

    // Next-state decode.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    if (op == OP_MUL) begin
                        next_state = BUSY;
                    end else if (is_shift(op) && (b[SHW-1:0] != {SHW{1'b0}})) begin
                        next_state = BUSY;
                    end else begin
                        next_state = DONE;
                    end
                end else begin
                    next_state = IDLE;
                end
            end
            BUSY: begin
                if (count == CNT_ONE) begin
                    next_state = DONE;
                end else begin
                    next_state = BUSY;
                end
            end
            DONE: begin
                if (out_ready) begin
                    next_state = IDLE;
                end else begin
                    next_state = DONE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Operand capture, iteration and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            opa       <= {WIDTH{1'b0}};
            product   <= {(2*WIDTH){1'b0}};
            count     <= {(SHW+1){1'b0}};
            op_reg    <= 4'd0;
            out_valid <= 1'b0;
            result    <= {WIDTH{1'b0}};
            flags     <= {FLAG_BITS{1'b0}};
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        opa     <= a;
                        product <= {{WIDTH{1'b0}}, b};
                        op_reg  <= op;
                        if (op == OP_MUL) begin
                            count <= CNT_FULL;
                        end else if (is_shift(op) && (b[SHW-1:0] != {SHW{1'b0}})) begin
                            count <= {1'b0, b[SHW-1:0]};
                        end else begin
                            out_valid <= 1'b1;
                            result    <= single_res;
                            flags     <= single_flags;
                        end
                    end
                end
                BUSY: begin
                    count <= count - CNT_ONE;
                    if (op_reg == OP_MUL) begin
                        product <= mul_next;
                    end else begin
                        opa <= shift_next;
                    end
                    if (count == CNT_ONE) begin
                        out_valid <= 1'b1;
                        if (op_reg == OP_MUL) begin
                            result <= mul_next[WIDTH-1:0];
                            flags  <= pack_flags(mul_next[WIDTH-1:0] == {WIDTH{1'b0}},
                                                 |mul_next[2*WIDTH-1:WIDTH], 1'b0);
                        end else begin
                            result <= shift_next;
                            flags  <= pack_flags(shift_next == {WIDTH{1'b0}}, 1'b0, 1'b0);
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: out_valid <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_alu.sv
// Scoreboard bench for multicycle_alu: directed cases plus random ops against a plain arithmetic model.
module tb_multicycle_alu;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [3:0]   op = 4'd0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] result;
    logic         zero;
    logic         overflow;
    logic         cout;

    typedef struct {
        logic [31:0] res;
        logic        z;
        logic        o;
        logic        c;
        int          acc;
        int          extra;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    bit   bp_mode = 1'b0;
    bit   bp_ready = 1'b0;
    bit   prev_v = 1'b0;

    multicycle_alu #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .overflow  (overflow),
        .cout      (cout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks = checks + 1;
        if (act !== req) begin
            failures = failures + 1;
            $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    function automatic exp_t model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        exp_t        e;
        logic [32:0] s;
        logic [63:0] p;
        e.res = 32'd0; e.o = 1'b0; e.c = 1'b0; e.acc = 0; e.extra = 0;
        case (o)
            4'd0: e.res = x & y;
            4'd1: e.res = x | y;
            4'd2: begin
                s     = {1'b0, x} + {1'b0, y};
                e.res = s[31:0];
                e.c   = s[32];
                e.o   = (x[31] == y[31]) && (s[31] != x[31]);
            end
            4'd6, 4'd7: begin
                s   = {1'b0, x} + {1'b0, ~y} + 33'd1;
                e.c = s[32];
                e.o = (x[31] != y[31]) && (s[31] != x[31]);
                if (o == 4'd6) e.res = s[31:0];
                else           e.res = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            end
            4'd8: begin
                p       = {32'd0, x} * {32'd0, y};
                e.res   = p[31:0];
                e.o     = |p[63:32];
                e.extra = 32;
            end
            4'd9: begin
                e.res   = x << y[4:0];
                e.extra = int'(y[4:0]);
            end
            4'd10: begin
                e.res   = x >> y[4:0];
                e.extra = int'(y[4:0]);
            end
            default: e.res = 32'd0;
        endcase
        e.z = (e.res == 32'd0);
        return e;
    endfunction

    // Consumer: random backpressure, or a fixed level when the main sequence takes over.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = bp_mode ? bp_ready : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: every valid cycle is compared with the scoreboard head; pop on transfer.
    always @(negedge clk) begin
        if (reset) begin
            prev_v = 1'b0;
        end else if (out_valid) begin
            chk("in_ready_while_valid", 64'(in_ready), 64'd0);
            if (sbq.size() == 0) begin
                chk("unexpected_out_valid", 64'(out_valid), 64'd0);
            end else begin
                mon_e = sbq[0];
                chk("result", 64'(result), 64'(mon_e.res));
                chk("zero", 64'(zero), 64'(mon_e.z));
                chk("overflow", 64'(overflow), 64'(mon_e.o));
                chk("cout", 64'(cout), 64'(mon_e.c));
                if (!prev_v) chk("latency", 64'(cyc - mon_e.acc), 64'(mon_e.extra));
                if (out_ready) void'(sbq.pop_front());
            end
            prev_v = !out_ready;
        end else begin
            prev_v = 1'b0;
        end
    end

    task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        exp_t e;
        int   n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("issue_timeout", 64'(in_ready), 64'd1);
        end else begin
            e     = model(o, x, y);
            e.acc = cyc + 1;
            sbq.push_back(e);
            in_valid = 1'b1;
            op = o; a = x; b = y;
            @(negedge clk);
            in_valid = 1'b0;
            op = 4'($urandom); a = $urandom; b = $urandom;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_result"}, 64'(result), 64'd0);
        chk({tag, "_zero"}, 64'(zero), 64'd0);
        chk({tag, "_overflow"}, 64'(overflow), 64'd0);
        chk({tag, "_cout"}, 64'(cout), 64'd0);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    endtask

    initial begin
        logic [3:0]  ops [10];
        logic [31:0] x;
        logic [31:0] y;
        int          n;
        ops = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd3, 4'd15};

        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        reset = 1'b0;
        @(negedge clk);
        chk("in_ready_after_reset", 64'(in_ready), 64'd1);

        issue(4'd2, 32'h7FFF_FFFF, 32'd1);
        issue(4'd6, 32'd45, 32'd15);
        issue(4'd7, 32'd75, 32'd120);
        issue(4'd7, 32'hFFFF_FFFF, 32'd1);
        issue(4'd7, 32'd5, 32'd5);
        issue(4'd8, 32'd13, 32'd16);
        issue(4'd8, 32'h0001_0000, 32'h0001_0000);
        issue(4'd9, 32'd1, 32'd31);
        issue(4'd10, 32'h8000_0000, 32'd0);
        issue(4'd15, $urandom, $urandom);

        for (int i = 0; i < 120; i++) begin
            x = $urandom;
            y = $urandom;
            if ($urandom_range(0, 3) == 0) x = x & 32'h0000_00FF;
            if ($urandom_range(0, 3) == 0) y = y & 32'hFFFF_FFE0;
            if ($urandom_range(0, 7) == 0) x = 32'h7FFF_FFFF + 32'($urandom_range(0, 1));
            issue(ops[$urandom_range(0, 9)], x, y);
        end

        // Backpressure: result held, in_ready low, new operands ignored.
        n = 0;
        while (sbq.size() != 0 && n < 300) begin @(negedge clk); n++; end
        bp_mode = 1'b1;
        bp_ready = 1'b0;
        repeat (2) @(negedge clk);
        issue(4'd2, 32'd100, 32'd23);
        n = 0;
        while (!out_valid && n < 50) begin @(negedge clk); n++; end
        for (int i = 0; i < 5; i++) begin
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            in_valid = 1'b1;
            op = 4'd8; a = $urandom; b = $urandom;
            @(negedge clk);
        end
        in_valid = 1'b0;
        bp_ready = 1'b1;
        n = 0;
        while (!(out_valid && out_ready) && n < 10) begin @(negedge clk); n++; end
        @(negedge clk);
        chk("bp_in_ready_after", 64'(in_ready), 64'd1);
        chk("bp_out_valid_after", 64'(out_valid), 64'd0);
        chk("bp_no_extra", 64'(sbq.size()), 64'd0);
        bp_mode = 1'b0;

        // Reset ten cycles into a multiply aborts it.
        issue(4'd8, $urandom, $urandom);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        sbq.delete();
        @(negedge clk);
        check_reset_outputs("mid_mul");
        repeat (2) @(negedge clk);
        check_reset_outputs("mid_mul_hold");
        reset = 1'b0;
        @(negedge clk);
        chk("in_ready_after_abort", 64'(in_ready), 64'd1);
        issue(4'd2, 32'd2, 32'd3);

        n = 0;
        while (sbq.size() != 0 && n < 1000) begin @(negedge clk); n++; end
        chk("drain", 64'(sbq.size()), 64'd0);
        repeat (40) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
